// File: rtl/branch_history_table.sv
// Branch history table: 2-bit saturating direction counters indexed by PC.
// Lookup is combinational from the fetch PC. Update happens on the clock edge
// from the execute-stage resolution. Resolved-branch and mispredict counters
// are kept for profiling.
module branch_history_table #(
   parameter int         INDEX_BITS = 5,
   parameter logic [1:0] INIT_STATE = 2'b01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc_i,
   input  logic        if_is_branch_i,
   output logic [1:0]  predict_o,
   input  logic        upd_valid_i,
   input  logic [31:0] upd_pc_i,
   input  logic        upd_taken_i,
   input  logic        upd_mispredict_i,
   input  logic        stats_clear_i,
   output logic [31:0] branch_cnt_o,
   output logic [31:0] mispredict_cnt_o
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic [INDEX_BITS-1:0] lookup_idx;
   logic [INDEX_BITS-1:0] upd_idx;
   logic [1:0]            entry_q [ENTRIES];
   logic [1:0]            lookup_entry;
   logic [1:0]            upd_entry;
   logic [1:0]            upd_entry_next;
   logic [31:0]           branch_cnt_reg;
   logic [31:0]           branch_cnt_next;
   logic [31:0]           mispredict_cnt_reg;
   logic [31:0]           mispredict_cnt_next;

   // Word-aligned PCs: bits [1:0] and everything above the index are untagged
   assign lookup_idx = if_pc_i[INDEX_BITS+1:2];
   assign upd_idx    = upd_pc_i[INDEX_BITS+1:2];

   // Bits that play no part in indexing are collected here to mark them as intentionally unused
   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc_i[31:INDEX_BITS+2], if_pc_i[1:0],
                             upd_pc_i[31:INDEX_BITS+2], upd_pc_i[1:0]};

   // Combinational read of the entry addressed by the fetch PC
   always_comb begin
      lookup_entry = entry_q[lookup_idx];
   end

   // Prediction: taken when the counter MSB is set, not-branch when nothing is fetched
   always_comb begin
      predict_o = 2'b00;
      if (if_is_branch_i) begin
         predict_o = lookup_entry[1] ? 2'b10 : 2'b01;
      end
   end

   // Saturating next value for the entry being trained
   always_comb begin
      upd_entry      = entry_q[upd_idx];
      upd_entry_next = upd_entry;
      if (upd_taken_i) begin
         if (upd_entry != 2'b11) upd_entry_next = upd_entry + 2'b01;
      end else begin
         if (upd_entry != 2'b00) upd_entry_next = upd_entry - 2'b01;
      end
   end

   // One flop pair per entry so reset can clear the whole table asynchronously;
   // lookup reads the pre-edge value, so same-index read/update is read-before-write
   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
         logic [1:0] entry_reg;

         // Train this entry only when the update addresses it
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               entry_reg <= INIT_STATE;
            end else if (upd_valid_i && (upd_idx == INDEX_BITS'(gi))) begin
               entry_reg <= upd_entry_next;
            end
         end

         assign entry_q[gi] = entry_reg;
      end
   endgenerate

   // Statistics next-state: clear wins over a same-cycle increment
   always_comb begin
      branch_cnt_next     = branch_cnt_reg;
      mispredict_cnt_next = mispredict_cnt_reg;
      if (stats_clear_i) begin
         branch_cnt_next     = 32'd0;
         mispredict_cnt_next = 32'd0;
      end else if (upd_valid_i) begin
         branch_cnt_next = branch_cnt_reg + 32'd1;
         if (upd_mispredict_i) mispredict_cnt_next = mispredict_cnt_reg + 32'd1;
      end
   end

   // Statistics registers, wrapping naturally at 2^32
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt_reg     <= 32'd0;
         mispredict_cnt_reg <= 32'd0;
      end else begin
         branch_cnt_reg     <= branch_cnt_next;
         mispredict_cnt_reg <= mispredict_cnt_next;
      end
   end

   assign branch_cnt_o     = branch_cnt_reg;
   assign mispredict_cnt_o = mispredict_cnt_reg;

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table: a vector table for the
// single-cycle behaviour, hand sequences for reset, statistics and wrap.
// Expectations go into a scoreboard queue when stimulus is driven and are
// compared when the corresponding output is sampled.
module tb_branch_history_table;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc_i;
   logic        if_is_branch_i;
   logic [1:0]  predict_o;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic        upd_taken_i;
   logic        upd_mispredict_i;
   logic        stats_clear_i;
   logic [31:0] branch_cnt_o;
   logic [31:0] mispredict_cnt_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   branch_history_table #(
      .INDEX_BITS (5),
      .INIT_STATE (2'b01)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .if_pc_i          (if_pc_i),
      .if_is_branch_i   (if_is_branch_i),
      .predict_o        (predict_o),
      .upd_valid_i      (upd_valid_i),
      .upd_pc_i         (upd_pc_i),
      .upd_taken_i      (upd_taken_i),
      .upd_mispredict_i (upd_mispredict_i),
      .stats_clear_i    (stats_clear_i),
      .branch_cnt_o     (branch_cnt_o),
      .mispredict_cnt_o (mispredict_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        upd_valid;
      logic [31:0] upd_pc;
      logic        upd_taken;
      logic        upd_mis;
      logic        clr;
      logic [31:0] lk_pc;
      logic        lk_br;
      logic [1:0]  exp_pred;   // predict_o just before the edge
      logic [31:0] exp_b;      // branch_cnt_o just after the edge
      logic [31:0] exp_m;      // mispredict_cnt_o just after the edge
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic t,
                               input logic m, input logic c, input logic [31:0] lpc,
                               input logic br, input logic [1:0] p,
                               input logic [31:0] b, input logic [31:0] mc);
      vec_t r;
      r.upd_valid = v;  r.upd_pc = pc;   r.upd_taken = t; r.upd_mis = m;
      r.clr       = c;  r.lk_pc  = lpc;  r.lk_br     = br;
      r.exp_pred  = p;  r.exp_b  = b;    r.exp_m     = mc;
      return r;
   endfunction

   task automatic push_exp(input string name, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input logic [31:0] act);
      exp_t e;
      total_cnt++;
      if (sb.size() == 0) begin
         $display("FAIL scoreboard_empty actual=%h required=<expectation>", act);
      end else begin
         e = sb.pop_front();
         if (act === e.exp) pass_cnt++;
         else $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic t,
                        input logic m, input logic c, input logic [31:0] lpc,
                        input logic br);
      upd_valid_i      = v;
      upd_pc_i         = pc;
      upd_taken_i      = t;
      upd_mispredict_i = m;
      stats_clear_i    = c;
      if_pc_i          = lpc;
      if_is_branch_i   = br;
   endtask

   task automatic apply(input int idx, input vec_t v);
      @(negedge clk);
      drive(v.upd_valid, v.upd_pc, v.upd_taken, v.upd_mis, v.clr, v.lk_pc, v.lk_br);
      push_exp($sformatf("v%0d_pred", idx), {30'd0, v.exp_pred});
      push_exp($sformatf("v%0d_bcnt", idx), v.exp_b);
      push_exp($sformatf("v%0d_mcnt", idx), v.exp_m);
      #1 pop_cmp({30'd0, predict_o});
      @(posedge clk);
      #1;
      pop_cmp(branch_cnt_o);
      pop_cmp(mispredict_cnt_o);
      $display("vec %0d: upd_v=%0b pc=%h t=%0b m=%0b clr=%0b lk=%h br=%0b -> bcnt=%0d mcnt=%0d",
               idx, v.upd_valid, v.upd_pc, v.upd_taken, v.upd_mis, v.clr, v.lk_pc, v.lk_br,
               branch_cnt_o, mispredict_cnt_o);
   endtask

   // Bounds the whole run in case anything stalls
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      rst = 1'b1;

      // Reset state and lookup while reset is held
      @(negedge clk);
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h1000_0040, 1'b1);
      push_exp("rst_pred_br", 32'd1);
      push_exp("rst_bcnt", 32'd0);
      push_exp("rst_mcnt", 32'd0);
      push_exp("rst_pred_nobr", 32'd0);
      #1;
      pop_cmp({30'd0, predict_o});
      pop_cmp(branch_cnt_o);
      pop_cmp(mispredict_cnt_o);
      if_is_branch_i = 1'b0;
      #1 pop_cmp({30'd0, predict_o});
      $display("reset: pred/counters checked with rst held");
      @(negedge clk);
      rst = 1'b0;

      // Vector table
      vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h1000_0040, 1, 2'b01, 0,  0));
      vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h1000_0040, 0, 2'b00, 0,  0));
      vecs.push_back(mk(1, 32'h1000_0008, 1, 1, 0, 32'h1000_0008, 1, 2'b01, 1,  1));
      vecs.push_back(mk(1, 32'h1000_0008, 1, 0, 0, 32'h1000_0008, 1, 2'b10, 2,  1));
      vecs.push_back(mk(1, 32'h1000_0008, 1, 0, 0, 32'h1000_0008, 1, 2'b10, 3,  1));
      vecs.push_back(mk(1, 32'h1000_0008, 1, 0, 0, 32'h1000_0008, 1, 2'b10, 4,  1));
      vecs.push_back(mk(1, 32'h1000_0008, 0, 1, 0, 32'h1000_0008, 1, 2'b10, 5,  2));
      vecs.push_back(mk(1, 32'h1000_0008, 0, 0, 0, 32'h1000_0008, 1, 2'b10, 6,  2));
      vecs.push_back(mk(0, 32'h1000_0008, 1, 1, 0, 32'h1000_0008, 1, 2'b01, 6,  2));
      vecs.push_back(mk(1, 32'h1000_0008, 0, 1, 0, 32'h1000_0008, 1, 2'b01, 7,  3));
      vecs.push_back(mk(1, 32'h1000_0008, 0, 0, 0, 32'h1000_0008, 1, 2'b01, 8,  3));
      vecs.push_back(mk(1, 32'h1000_0008, 0, 0, 0, 32'h1000_0008, 1, 2'b01, 9,  3));
      vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h1000_0008, 0, 2'b00, 9,  3));
      vecs.push_back(mk(1, 32'h1000_0008, 1, 0, 0, 32'h1000_0008, 1, 2'b01, 10, 3));
      vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h1000_0008, 1, 2'b01, 10, 3));
      vecs.push_back(mk(1, 32'h1000_0008, 1, 0, 0, 32'h1000_0008, 1, 2'b01, 11, 3));
      vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h1000_0008, 1, 2'b10, 11, 3));
      vecs.push_back(mk(1, 32'h0000_0004, 1, 0, 0, 32'h0000_0084, 1, 2'b01, 12, 3));
      vecs.push_back(mk(1, 32'h0000_0004, 1, 0, 0, 32'h0000_000C, 1, 2'b01, 13, 3));
      vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0000_0084, 1, 2'b10, 13, 3));
      vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0000_000C, 1, 2'b01, 13, 3));
      vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h1000_0006, 1, 2'b10, 13, 3));
      vecs.push_back(mk(1, 32'h0000_0010, 1, 1, 1, 32'h0000_0010, 1, 2'b01, 0,  0));
      vecs.push_back(mk(0, 32'h0,         0, 0, 0, 32'h0000_0010, 1, 2'b10, 0,  0));

      for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

      // Asynchronous reset between edges while an update is pending
      @(negedge clk);
      drive(1'b1, 32'h18, 1'b1, 1'b0, 1'b0, 32'h18, 1'b1);
      @(negedge clk);
      push_exp("ar_pre_pred", 32'd2);
      #1 pop_cmp({30'd0, predict_o});                 // entry 6 now 2 -> taken
      @(negedge clk);                                 // entry 6 now 3
      push_exp("ar_before_rst", 32'd2);
      push_exp("ar_pred_immediate", 32'd1);
      push_exp("ar_other_entry", 32'd1);
      push_exp("ar_pred_nobr", 32'd0);
      push_exp("ar_bcnt_immediate", 32'd0);
      #1 pop_cmp({30'd0, predict_o});
      #2 rst = 1'b1;
      #1 pop_cmp({30'd0, predict_o});
      if_pc_i = 32'h0000_0010;                         // entry 4 was trained to 2
      #1 pop_cmp({30'd0, predict_o});
      if_is_branch_i = 1'b0;
      #1 pop_cmp({30'd0, predict_o});
      pop_cmp(branch_cnt_o);
      $display("async reset: applied between edges with upd_valid=1");
      @(posedge clk);                                 // update attempted under reset
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h18, 1'b1);
      push_exp("ar_discarded_pred", 32'd1);
      push_exp("ar_discarded_bcnt", 32'd0);
      #1;
      pop_cmp({30'd0, predict_o});
      pop_cmp(branch_cnt_o);
      @(negedge clk);
      drive(1'b1, 32'h18, 1'b1, 1'b0, 1'b0, 32'h18, 1'b1);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h18, 1'b1);
      push_exp("ar_resume_pred", 32'd2);
      push_exp("ar_resume_bcnt", 32'd1);
      #1;
      pop_cmp({30'd0, predict_o});
      pop_cmp(branch_cnt_o);
      $display("async reset: update resumed after deassertion");

      // Statistics: 10 updates, 3 of them mispredicted
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(1'b1, 32'h20, i[0], (i == 1 || i == 4 || i == 7), 1'b0, 32'h0, 1'b0);
      end
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      push_exp("stats_bcnt", 32'd10);
      push_exp("stats_mcnt", 32'd3);
      #1;
      pop_cmp(branch_cnt_o);
      pop_cmp(mispredict_cnt_o);
      $display("stats: 10 updates / 3 mispredicts -> bcnt=%0d mcnt=%0d",
               branch_cnt_o, mispredict_cnt_o);

      // Wrap from all-ones to zero
      @(negedge clk);
      force dut.branch_cnt_reg     = 32'hFFFF_FFFF;
      force dut.mispredict_cnt_reg = 32'hFFFF_FFFF;
      #1;
      release dut.branch_cnt_reg;
      release dut.mispredict_cnt_reg;
      drive(1'b1, 32'h24, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      push_exp("wrap_bcnt", 32'd0);
      push_exp("wrap_mcnt", 32'd0);
      @(posedge clk);
      #1;
      pop_cmp(branch_cnt_o);
      pop_cmp(mispredict_cnt_o);
      $display("wrap: bcnt=%h mcnt=%h", branch_cnt_o, mispredict_cnt_o);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      total_cnt += 0;
      if (sb.size() != 0) begin
         total_cnt++;
         $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
      end
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
